// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, tracking the single outstanding read.
// Define MEMARB_ROUNDROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_start,
  output logic        i_cmd_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
  state_t state;
  logic idle, gnt_i, gnt_d;
  assign idle = (state == IDLE) && !rst;
`ifdef MEMARB_ROUNDROBIN_EN
  logic last_d;
  assign gnt_d = idle && d_cmd_start && !(i_cmd_start && last_d);
`else
  assign gnt_d = idle && d_cmd_start;
`endif
  assign gnt_i = idle && i_cmd_start && !gnt_d;
  assign mem_cmd_start = gnt_i || gnt_d;
  assign mem_cmd_write = gnt_d && d_cmd_write;
  assign mem_addr = gnt_d ? d_addr : gnt_i ? i_addr : '1;
  assign mem_wdata = gnt_d ? d_wdata : '1;
  assign mem_wmask = gnt_d ? d_wmask : '1;
  assign i_cmd_ready = gnt_i && mem_cmd_ready;
  assign d_cmd_ready = gnt_d && mem_cmd_ready;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_rdata_valid = !rst && (state == WAIT_I) && mem_rdata_valid;
  assign d_rdata_valid = !rst && (state == WAIT_D) && mem_rdata_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
`ifdef MEMARB_ROUNDROBIN_EN
      last_d <= 1'b1;
`endif
    end else begin
      if (state != IDLE && mem_rdata_valid) state <= IDLE;
      else if (i_cmd_ready) state <= WAIT_I;
      else if (d_cmd_ready) state <= d_cmd_write ? IDLE : WAIT_D;
`ifdef MEMARB_ROUNDROBIN_EN
      if (i_cmd_ready || d_cmd_ready) last_d <= d_cmd_ready;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with expected commands/responses queued and checked by a monitor.
module tb_mem_port_arbiter;
  logic clk = 0, rst;
  logic i_cmd_start, i_cmd_ready, i_rdata_valid;
  logic [31:0] i_addr, i_rdata;
  logic d_cmd_start, d_cmd_write, d_cmd_ready, d_rdata_valid;
  logic [31:0] d_addr, d_wdata, d_wmask, d_rdata;
  logic mem_cmd_start, mem_cmd_write, mem_cmd_ready, mem_rdata_valid;
  logic [31:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_cmd_start(i_cmd_start), .i_cmd_ready(i_cmd_ready), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write), .d_cmd_ready(d_cmd_ready),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write), .mem_cmd_ready(mem_cmd_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {logic d; logic w; logic [31:0] a; logic [31:0] wd; logic [31:0] m;} cmd_t;
  typedef struct {logic d; logic [31:0] data;} rsp_t;
  cmd_t cq[$];
  rsp_t rq[$];
  cmd_t mc, ci, cd;
  rsp_t mr;
  int n_cmp = 0, n_err = 0;
  logic i_first;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mem_cmd_start && mem_cmd_ready) begin
      if (cq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_cmd actual addr=%h required none", mem_addr);
      end else begin
        mc = cq.pop_front();
        chk("cmd_src_ready", {30'b0, d_cmd_ready, i_cmd_ready}, mc.d ? 32'd2 : 32'd1);
        chk("cmd_write", {31'b0, mem_cmd_write}, {31'b0, mc.w});
        chk("cmd_addr", mem_addr, mc.a);
        chk("cmd_wdata", mem_wdata, mc.wd);
        chk("cmd_wmask", mem_wmask, mc.m);
      end
    end
    if (i_rdata_valid || d_rdata_valid) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp actual i=%b d=%b required none", i_rdata_valid, d_rdata_valid);
      end else begin
        mr = rq.pop_front();
        chk("rsp_src", {30'b0, d_rdata_valid, i_rdata_valid}, mr.d ? 32'd2 : 32'd1);
        chk("rsp_data", mr.d ? d_rdata : i_rdata, mr.data);
      end
    end
  end

  initial begin
`ifdef MEMARB_ROUNDROBIN_EN
    i_first = 1'b1;
`else
    i_first = 1'b0;
`endif
    rst = 1; i_cmd_start = 1; i_addr = 32'h100; d_cmd_start = 1; d_cmd_write = 1;
    d_addr = 0; d_wdata = 0; d_wmask = 0; mem_cmd_ready = 1;
    mem_rdata = 32'hcafef00d; mem_rdata_valid = 1;
    neg;
    chk("rst_mem_start", {31'b0, mem_cmd_start}, 0);
    chk("rst_mem_write", {31'b0, mem_cmd_write}, 0);
    chk("rst_i_ready", {31'b0, i_cmd_ready}, 0);
    chk("rst_d_ready", {31'b0, d_cmd_ready}, 0);
    chk("rst_i_valid", {31'b0, i_rdata_valid}, 0);
    chk("rst_d_valid", {31'b0, d_rdata_valid}, 0);
    chk("rst_mem_addr", mem_addr, 32'hffffffff);
    chk("rst_mem_wmask", mem_wmask, 32'hffffffff);
    chk("rst_i_rdata", i_rdata, 32'hcafef00d);
    tick;
    rst = 0; i_cmd_start = 0; d_cmd_start = 0; d_cmd_write = 0; mem_rdata_valid = 0;
    neg;
    chk("idle_start", {31'b0, mem_cmd_start}, 0);
    chk("idle_wdata", mem_wdata, 32'hffffffff);
    chk("idle_wmask", mem_wmask, 32'hffffffff);
    // fetch read alone
    tick;
    i_cmd_start = 1; i_addr = 32'h100;
    cq.push_back('{1'b0, 1'b0, 32'h100, 32'hffffffff, 32'hffffffff});
    neg;
    chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_i_ready", {31'b0, i_cmd_ready}, 1);
    tick;
    i_cmd_start = 0;
    tick;
    mem_rdata = 32'hdeadbeef; mem_rdata_valid = 1;
    rq.push_back('{1'b0, 32'hdeadbeef});
    neg;
    chk("fetch_d_valid", {31'b0, d_rdata_valid}, 0);
    tick;
    mem_rdata_valid = 0;
    // back-to-back stores
    d_cmd_start = 1; d_cmd_write = 1; d_addr = 32'h2000; d_wdata = 32'h55; d_wmask = 32'hff;
    repeat (2) cq.push_back('{1'b1, 1'b1, 32'h2000, 32'h55, 32'hff});
    neg;
    chk("wr0_ready", {31'b0, d_cmd_ready}, 1);
    tick;
    neg;
    chk("wr1_ready", {31'b0, d_cmd_ready}, 1);
    tick;
    // simultaneous reads
    d_cmd_write = 0; d_addr = 32'h200; d_wdata = 32'h77; d_wmask = 32'hf0;
    i_cmd_start = 1; i_addr = 32'h100;
    ci = '{1'b0, 1'b0, 32'h100, 32'hffffffff, 32'hffffffff};
    cd = '{1'b1, 1'b0, 32'h200, 32'h77, 32'hf0};
    cq.push_back(i_first ? ci : cd);
    neg;
    chk("sim_i_ready", {31'b0, i_cmd_ready}, {31'b0, i_first});
    chk("sim_d_ready", {31'b0, d_cmd_ready}, {31'b0, !i_first});
    tick;
    if (i_first) i_cmd_start = 0; else d_cmd_start = 0;
    repeat (2) begin
      neg;
      chk("blk_start", {31'b0, mem_cmd_start}, 0);
      chk("blk_ready", {31'b0, i_cmd_ready | d_cmd_ready}, 0);
      tick;
    end
    mem_rdata = 32'ha5a5a5a5; mem_rdata_valid = 1;
    rq.push_back('{!i_first, 32'ha5a5a5a5});
    neg;
    chk("blk_vcyc_start", {31'b0, mem_cmd_start}, 0);
    chk("blk_vcyc_ready", {31'b0, i_cmd_ready | d_cmd_ready}, 0);
    tick;
    mem_rdata_valid = 0;
    cq.push_back(i_first ? cd : ci);
    neg;
    chk("sim_other_ready", {31'b0, i_first ? d_cmd_ready : i_cmd_ready}, 1);
    tick;
    i_cmd_start = 0; d_cmd_start = 0;
    tick;
    mem_rdata = 32'h12345678; mem_rdata_valid = 1;
    rq.push_back('{i_first, 32'h12345678});
    neg;
    tick;
    mem_rdata_valid = 0;
    // stall with ready low for three cycles
    d_cmd_start = 1; d_cmd_write = 0; d_addr = 32'h300; d_wdata = 0; d_wmask = 32'h0f;
    mem_cmd_ready = 0;
    repeat (3) begin
      neg;
      chk("stall_ready", {31'b0, d_cmd_ready}, 0);
      chk("stall_start", {31'b0, mem_cmd_start}, 1);
      tick;
    end
    mem_cmd_ready = 1;
    cq.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 32'h0f});
    neg;
    chk("stall_accept", {31'b0, d_cmd_ready}, 1);
    tick;
    d_cmd_start = 0;
    mem_rdata = 32'h0000beef; mem_rdata_valid = 1;
    rq.push_back('{1'b1, 32'h0000beef});
    neg;
    tick;
    // stray valid in IDLE
    mem_rdata = 32'hbad0bad0;
    neg;
    chk("drop_i_valid", {31'b0, i_rdata_valid}, 0);
    chk("drop_d_valid", {31'b0, d_rdata_valid}, 0);
    tick;
    mem_rdata_valid = 0;
    // reset while fetch read outstanding
    i_cmd_start = 1; i_addr = 32'h400;
    cq.push_back('{1'b0, 1'b0, 32'h400, 32'hffffffff, 32'hffffffff});
    neg;
    tick;
    i_cmd_start = 0; rst = 1;
    neg;
    tick;
    rst = 0; mem_rdata_valid = 1;
    neg;
    chk("late_i_valid", {31'b0, i_rdata_valid}, 0);
    chk("late_d_valid", {31'b0, d_rdata_valid}, 0);
    tick;
    mem_rdata_valid = 0;
    i_cmd_start = 1; i_addr = 32'h500;
    cq.push_back('{1'b0, 1'b0, 32'h500, 32'hffffffff, 32'hffffffff});
    neg;
    chk("post_rst_ready", {31'b0, i_cmd_ready}, 1);
    tick;
    i_cmd_start = 0; mem_rdata = 32'h0000600d; mem_rdata_valid = 1;
    rq.push_back('{1'b0, 32'h0000600d});
    neg;
    tick;
    mem_rdata_valid = 0;
    neg;
    chk("cmd_queue_left", cq.size(), 0);
    chk("rsp_queue_left", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core memory port between the instruction-fetch requester (read-only, `i_*`) and the memory-stage requester (read/write, `d_*`). It sits between both pipeline stages and the memory controller, grants the port to one requester per command, tracks the single outstanding read, and routes `rdata_valid` back to its owner. The arbiter adds no latency: requests pass through combinationally in the grant cycle.

## Interface
- No parameters; address, data and mask widths are fixed at 32 bits.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous reset, active-high.
- `i_cmd_start` in 1: fetch read request.
- `i_cmd_ready` out 1: fetch command accepted this cycle when high together with `i_cmd_start`.
- `i_addr` in 32: fetch address.
- `i_rdata` out 32: read data, equal to `mem_rdata`.
- `i_rdata_valid` out 1: fetch read data valid.
- `d_cmd_start` in 1: data request.
- `d_cmd_write` in 1: 1 = store, 0 = load.
- `d_cmd_ready` out 1: data command accepted.
- `d_addr`, `d_wdata`, `d_wmask` in 32 each: data address, store data and byte-lane mask.
- `d_rdata` out 32: equal to `mem_rdata`.
- `d_rdata_valid` out 1: data read valid.
- `mem_cmd_start`, `mem_cmd_write` out 1: downstream command.
- `mem_cmd_ready` in 1: downstream ready.
- `mem_addr`, `mem_wdata`, `mem_wmask` out 32: downstream address, write data and mask.
- `mem_rdata` in 32: downstream read data.
- `mem_rdata_valid` in 1: downstream read valid.

## Operation
- States:
  - `IDLE`: no read outstanding.
  - `WAIT_I`: fetch read outstanding.
  - `WAIT_D`: data read outstanding.
- In `IDLE`, the grant is computed combinationally from `i_cmd_start` and `d_cmd_start`; see Configuration for the priority rule.
- The granted requester drives `mem_*`:
  - `mem_cmd_start` = granted start.
  - `mem_cmd_write` = `d_cmd_write` if data is granted, else 0.
  - `mem_wmask` = `d_wmask` when data is granted, else 0xffffffff.
- Ready routing: granted `*_cmd_ready` = `mem_cmd_ready` in `IDLE`; the non-granted ready is 0.
- Acceptance is `*_cmd_start && *_cmd_ready`. On acceptance:
  - fetch read → `WAIT_I`
  - data read → `WAIT_D`
  - data write → stays `IDLE`; writes have no response.
- In `WAIT_I` and `WAIT_D`:
  - `mem_cmd_start`, `i_cmd_ready` and `d_cmd_ready` are 0.
  - `mem_addr`, `mem_wdata` and `mem_wmask` are 0xffffffff.
- Read response routing:
  - `i_rdata_valid` = `mem_rdata_valid` in `WAIT_I`, else 0.
  - `d_rdata_valid` = `mem_rdata_valid` in `WAIT_D`, else 0.
  - On `mem_rdata_valid`, the FSM returns to `IDLE`.
- A `mem_rdata_valid` in `IDLE` is a protocol error. It is dropped: no requester valid is raised.
- No starting request in `IDLE`: all `mem_*` command outputs are idle (start 0, write 0, data/mask 0xffffffff).

## Timing
- Reset values: state `IDLE`, round-robin pointer = data.
- While `rst` is high, all outputs are forced to 0 except `*_rdata` (pass-through) and `mem_addr`/`mem_wdata`/`mem_wmask` (0xffffffff).
- Request to `mem_cmd_start`: 0 cycles (combinational).
- Response: `mem_rdata_valid` to `*_rdata_valid` is 0 cycles.
- The earliest next command is the cycle after the valid cycle; there is no same-cycle reissue.
- Back-to-back writes: one per cycle while `mem_cmd_ready` is high.
- Requesters hold start, address and data stable until accepted. The arbiter does not latch command fields.
- The grant may change between cycles while `mem_cmd_ready` is low. It is only committed on acceptance.
- Reset mid-read: the FSM returns to `IDLE`. A late `mem_rdata_valid` after reset is dropped as in `IDLE`.

## Configuration
- `MEMARB_ROUNDROBIN_EN` undefined: fixed priority. Data wins any simultaneous request; fetch may starve.
- `MEMARB_ROUNDROBIN_EN` defined: round-robin.
  - A 1-bit pointer records the last accepted requester.
  - On a simultaneous request, the other requester wins.
  - The pointer updates only on acceptance; a single requester always wins.

## Test plan
- Fetch read alone: `i_cmd_start`=1, `i_addr`=0x100, `mem_cmd_ready`=1 → `mem_addr`=0x100 the same cycle, `mem_cmd_write`=0, state `WAIT_I`. Then `mem_rdata_valid` with 0xdeadbeef → `i_rdata_valid`=1, `i_rdata`=0xdeadbeef, `d_rdata_valid`=0.
- Data store: `d_addr`=0x2000, `d_wdata`=0x55, `d_wmask`=0xff, write=1 → `mem_cmd_write`=1, `mem_wmask`=0xff. Repeat next cycle: two accepts in 2 cycles, state stays `IDLE`.
- Simultaneous reads at 0x100 (i) and 0x200 (d), fixed priority: d is granted first, then i after d's valid. With `MEMARB_ROUNDROBIN_EN` and last grant = d: i is granted first.
- Stall: `mem_cmd_ready`=0 for 3 cycles with `d_cmd_start` held → `d_cmd_ready`=0, no state change. Accept on cycle 4.
- Outstanding block: in `WAIT_D`, `i_cmd_start`=1 → `mem_cmd_start`=0 and `i_cmd_ready`=0 until the cycle after `mem_rdata_valid`.
- Reset in `WAIT_I`: assert `rst`, then `mem_rdata_valid`=1 after release → both `*_rdata_valid`=0, state `IDLE`.
